uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised, buffered UART transmitter. It is the next-generation serial output stage for the Basys3 designs. It accepts words over a valid/ready handshake into a small FIFO and serialises them LSB-first on TxD. Data width, parity mode, stop-bit count and baud divisor are all configurable. Queued frames are sent back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 28, clk cycles per serial bit (clk / baud); legal range >= 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_DEPTH, 4, words of transmit buffering; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_valid  input  1  tx_data holds a word to queue
tx_data  input  DATA_BITS  word to transmit
tx_ready  output  1  FIFO can accept a word; equals !full
TxD  output  1  serial line; idles high
busy  output  1  a frame is on the line, or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight

Behaviour:
- Reset: asynchronous, active-high, clk is the only clock.
  - Reset values: TxD=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, baud counter=0, bit counter=0.
  - Reset asserted mid-frame aborts the frame: TxD is forced to 1 immediately (no clock needed) and the FIFO is flushed.
- Handshake:
  - A word is accepted on a rising clk edge where tx_valid && tx_ready.
  - When full, tx_ready=0 and tx_valid is ignored. The word is not lost; the source holds it.
  - tx_ready depends only on fill level. There is no combinational path from tx_valid.
- FSM states: IDLE, START, DATA, PAR, STOP. TxD is driven from a register, so it is glitch-free.
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, go to START.
  - START: TxD=0.
  - DATA: TxD=shift[0]. Shift right once per bit, DATA_BITS bits in total.
  - PAR (only when PARITY!=0): even mode sends XOR of the data bits; odd mode sends its inverse. Parity is computed from the popped word, not from the shift register.
  - STOP: TxD=1 for STOP_BITS bit periods.
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles. The baud counter restarts at 0 at each frame start.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. TxD falls at edge N+2.
- Back-to-back: at the end of the last stop bit, if the FIFO is non-empty, the next word is popped on that same edge and START begins immediately. The next TxD low follows the last stop-bit cycle with no extra idle cycle.
- Simultaneous push and pop: both are honoured and fifo_count is unchanged. Push while full is not possible because tx_ready=0.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty are derived from pointers that carry one extra bit.
- tx_data changes while the FSM is in a state other than IDLE have no effect on the frame in flight.
- busy=0 only when the FSM is IDLE and fifo_count=0.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, PAR, STOP)
  - parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2
  - a frame-length helper function
- One sub-module: uart_tx_fifo. It is a synchronous FIFO parametrised by WIDTH and DEPTH, with push, pop, full, empty and count ports, and the same asynchronous reset.
- The baud counter and FSM stay in uart_tx_param.

Test Plan:
1. Defaults (8N1, CLKS_PER_BIT=28), send 0xA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 28 cycles (280 cycles total). Start bit falls 2 edges after accept. busy drops after the stop bit.
2. PARITY=2, then PARITY=1, send 0xA5 -> parity bit is 0 in even mode and 1 in odd mode, placed after data bit 7. Frame is 11 bits (308 cycles).
3. STOP_BITS=2, DATA_BITS=7, send 0x7F -> 0, seven 1s, then stop high for 56 cycles. Frame is 280 cycles.
4. Burst of 6 words (0x01..0x06) with tx_valid held high and FIFO_DEPTH=4 -> tx_ready drops when 4 are queued. All 6 are sent in order with no idle cycle between frames. fifo_count returns to 0.
5. Assert reset at bit 4 of a frame with 2 words queued -> TxD=1 immediately, fifo_count=0, busy=0. After release, no residual frame is sent.
6. Push on the same edge as the IDLE pop, with 1 word queued -> fifo_count stays 1, and both words are transmitted in order.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared FSM state encoding, parity mode constants and a
//             frame-length helper for the buffered UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Small synchronous FIFO with first-word fall-through read data.
//             Pointers carry one extra wrap bit to separate full from empty.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers wrap modulo DEPTH through their low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param
//  Purpose  : Buffered, parametrised UART transmitter. Words enter a FIFO via
//             valid/ready and are serialised LSB-first, frames back-to-back.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 28,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 txd_q;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;
    logic                 bit_done;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign tx_ready    = !full;
    assign push        = tx_valid && !full;
    assign busy        = (state != IDLE) || !empty;
    assign bit_done    = (baud_cnt == BAUD_LAST);
    // Parity is taken from the word as it leaves the FIFO.
    assign head_parity = (PARITY == PARITY_EVEN) ? ^head : ~^head;
    assign TxD         = txd_q;

    // State, baud/bit counters, shift register and latched parity bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_bit  <= par_n;
        end
    end

    // Next-state logic; a pop loads the frame either from IDLE or at the
    // end of the last stop bit so queued frames leave with no gap.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_bit;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = head_parity;
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY != PARITY_NONE) ? PAR : STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            PAR: begin
                if (bit_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_n = head;
                            par_n   = head_parity;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered line driver, one cycle behind the state; reset forces idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd_q <= 1'b1;
        end else begin
            case (state)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shift[0];
                PAR:     txd_q <= par_bit;
                default: txd_q <= 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire
